// File: rtl/wide_adder_sequencer.sv
// Multi-cycle wide adder: one width-bit slice per cycle with the carry chained between slices.
// Optional macro WIDE_ADDER_SUB_EN adds a captured `sub` input for two's-complement subtraction.

module prefix_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  // Kogge-Stone: g[l][i] is the group generate of bits i..max(0,i-2^l+1), with cin folded into bit 0
  logic [5:0][31:0] g;
  logic [4:0][31:0] p;

  assign p[0] = a ^ b;
  assign g[0] = (a & b) | {31'b0, p[0][0] & cin};

  genvar l, i;
  generate
    for (l = 1; l <= 5; l++) begin : g_lvl
      localparam int D = 1 << (l - 1);
      for (i = 0; i < 32; i++) begin : g_bit
        if (i >= D) begin : g_cmb
          assign g[l][i] = g[l-1][i] | (p[l-1][i] & g[l-1][i-D]);
          if (l < 5) begin : g_p
            assign p[l][i] = p[l-1][i] & p[l-1][i-D];
          end
        end else begin : g_pass
          assign g[l][i] = g[l-1][i];
          if (l < 5) begin : g_p
            assign p[l][i] = p[l-1][i];
          end
        end
      end
    end
  endgenerate

  assign s    = p[0] ^ {g[5][30:0], cin};
  assign cout = g[5][31];
endmodule

module wide_adder_sequencer #(
  parameter int width = 32,
  parameter int words = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [width*words-1:0] a,
  input  logic [width*words-1:0] b,
  input  logic                   cin,
`ifdef WIDE_ADDER_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [width*words-1:0] s,
  output logic                   cout
);
  localparam int OW = width * words;
  localparam int KW = (words > 1) ? $clog2(words) : 1;
  localparam logic [KW-1:0] KLAST = KW'(words - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [OW-1:0]     a_q, b_q;
  logic              c;
  logic [width-1:0]  sa, sb, sum;
  logic              co;

  assign sa = a_q[k*width +: width];
`ifdef WIDE_ADDER_SUB_EN
  logic sub_q;
  assign sb = b_q[k*width +: width] ^ {width{sub_q}};
`else
  assign sb = b_q[k*width +: width];
`endif

  generate
    if (width == 32) begin : g_pfx
      prefix_adder_32 u_add (.a(sa), .b(sb), .cin(c), .s(sum), .cout(co));
    end else begin : g_beh
      assign {co, sum} = {1'b0, sa} + {1'b0, sb} + {{width{1'b0}}, c};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      c     <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
`ifdef WIDE_ADDER_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          k     <= '0;
          a_q   <= a;
          b_q   <= b;
          s     <= '0;
          cout  <= 1'b0;
`ifdef WIDE_ADDER_SUB_EN
          sub_q <= sub;
          // Subtraction is a + ~b + 1, so slice 0 carry is forced high
          c     <= sub | cin;
          if (sub) c <= 1'b1;
`else
          c     <= cin;
`endif
        end
        RUN: begin
          s[k*width +: width] <= sum;
          c <= co;
          if (k == KLAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= co;
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
